// File: rtl/mult5_row_seq_if.sv
// Handshake and data bundle for the sequential row multiplier.
// The master launches a multiply. The slave (the multiplier) reports busy/done and the product.
interface mult5_row_seq_if #(
    parameter int W = 5
);
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mult5_row_seq.sv
// Sequential unsigned W x W multiplier.
// One row of adder cells (a half adder at the LSB, full adders above it) is reused once per clock.
// Each pass folds one partial-product row into the accumulator.
module mult5_row_seq #(
    parameter int W = 5
) (
    input  logic            clk,
    input  logic            rst,
    mult5_row_seq_if.slave  bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    // The top W-1 bits are zero, so the row result (W sums plus carry) can be shifted into place.
    localparam logic [2*W-1:0] ROW_MASK = {{(W-1){1'b0}}, {(W+1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [2*W-1:0]   acc_reg;
    logic [CW-1:0]    cnt_reg;
    logic [2*W-1:0]   product_reg;
    logic             busy_reg;
    logic             done_reg;

    // Row datapath: acc[cnt +: W] + (b_r[cnt] ? a_r : 0).
    logic [W-1:0]     row_x;
    logic [W-1:0]     row_y;
    logic [W-1:0]     row_sum;
    logic [W:1]       row_carry;
    logic [2*W-1:0]   row_word;
    logic [2*W-1:0]   acc_next;

    assign row_x = W'(acc_reg >> cnt_reg);
    assign row_y = {W{b_reg[cnt_reg]}} & a_reg;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_cell
            if (gi == 0) begin : g_ha
                assign row_sum[0]   = row_x[0] ^ row_y[0];
                assign row_carry[1] = row_x[0] & row_y[0];
            end else begin : g_fa
                assign row_sum[gi]      = row_x[gi] ^ row_y[gi] ^ row_carry[gi];
                assign row_carry[gi+1]  = (row_x[gi] & row_y[gi])
                                        | (row_carry[gi] & (row_x[gi] ^ row_y[gi]));
            end
        end
    endgenerate

    // Bits cnt..cnt+W are replaced by the row result. The bits below them are already final.
    // Bit cnt+W is known to be zero before the add, so the carry lands there cleanly.
    assign row_word = {{(W-1){1'b0}}, row_carry[W], row_sum};
    assign acc_next = (acc_reg & ~(ROW_MASK << cnt_reg)) | (row_word << cnt_reg);

    // Control FSM with registered handshake outputs. rst overrides everything, including a multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    if (cnt_reg == CW'(W - 1)) begin
                        product_reg <= acc_next;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_reg;
    assign bus.done    = done_reg;
    assign bus.product = product_reg;
endmodule
